// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the pipelined byte-addressable memory:
//   - mem_state_e   : request/response FSM states
//   - DEF_*         : default parameter values for pipelined_memory
//   - byte_index()  : maps (byte address, lane) to a wrapped array index
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_BYTES = 8;
    localparam int DEF_DEPTH      = 65536;
    localparam int DEF_LATENCY    = 1;

    // Byte lane i of an access at addr touches (addr + i) mod depth.
    // depth is a power of two, so the modulo is a mask.
    function automatic logic [31:0] byte_index(input logic [31:0] addr,
                                               input int unsigned lane,
                                               input int unsigned depth);
        return (addr + lane) & (depth - 1);
    endfunction

endpackage

// File: rtl/mem_byte_bank.sv
// -----------------------------------------------------------------------------
// mem_byte_bank
// Byte-wide storage array with one write port and one read port per lane.
// Writes take effect on the rising clock edge; reads are combinational so the
// caller can capture read data on the same edge that accepts the request.
// The array is deliberately not reset.
//
// Ports:
//   clk      in   clock
//   wr_en    in   per-lane write enable
//   wr_idx   in   per-lane write index
//   wr_data  in   per-lane write byte
//   rd_idx   in   per-lane read index
//   rd_data  out  per-lane read byte
// -----------------------------------------------------------------------------
module mem_byte_bank #(
    parameter int DEPTH      = 65536,
    parameter int DATA_BYTES = 8,
    parameter int IDX_W      = 16
) (
    input  logic                  clk,
    input  logic [DATA_BYTES-1:0] wr_en,
    input  logic [IDX_W-1:0]      wr_idx  [DATA_BYTES],
    input  logic [7:0]            wr_data [DATA_BYTES],
    input  logic [IDX_W-1:0]      rd_idx  [DATA_BYTES],
    output logic [7:0]            rd_data [DATA_BYTES]
);

    logic [7:0] mem_q [DEPTH];

    // Lanes of one access always address distinct bytes (DEPTH >= DATA_BYTES),
    // so the per-lane writes never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            rd_data[i] = mem_q[rd_idx[i]];
        end
    end

endmodule

// File: rtl/pipelined_memory.sv
// -----------------------------------------------------------------------------
// pipelined_memory
// Single-outstanding-request byte-addressable memory with a fixed response
// latency. A request is accepted when req_valid && req_ready; writes commit and
// reads capture their data on the accept edge, and the response is presented
// LATENCY cycles later and held until resp_ready.
//
// Optional feature (compile-time macro MEM_BOUNDS_CHECK_EN):
//   defined   - accesses whose last byte lies at or above DEPTH write nothing,
//               return zero data and set resp_err; no wrap-around.
//   undefined - resp_err is always 0 and byte addresses wrap modulo DEPTH.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted (IDLE only)
//   req_we      in   1 = write, 0 = read
//   req_mask    in   per-byte write enable
//   req_addr    in   byte address, any alignment
//   req_wdata   in   write data, little-endian
//   resp_valid  out  response present
//   resp_ready  in   response consumed
//   resp_rdata  out  read data, little-endian, zero for writes
//   resp_err    out  access faulted (bounds check only)
// -----------------------------------------------------------------------------
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_BYTES = DEF_DATA_BYTES,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_BYTES-1:0]   req_mask,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*DATA_BYTES-1:0] resp_rdata,
    output logic                    resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    mem_state_e              state_q,      state_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [8*DATA_BYTES-1:0] rdata_q,      rdata_d;
    logic                    err_q,        err_d;

    logic                    accept;
    logic                    oob;
    logic [DATA_BYTES-1:0]   bank_we;
    logic [IDX_W-1:0]        lane_idx   [DATA_BYTES];
    logic [7:0]              lane_wdata [DATA_BYTES];
    logic [7:0]              lane_rdata [DATA_BYTES];
    logic [8*DATA_BYTES-1:0] rd_word;

    // Ready is held low while reset is asserted so nothing is offered as
    // acceptable until the block has actually left reset.
    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef MEM_BOUNDS_CHECK_EN
    // The last byte address is computed one bit wider so an access running
    // past the top of the address space is caught rather than wrapped.
    logic [ADDR_W:0] last_addr;

    always_comb begin
        last_addr = {1'b0, req_addr} + (ADDR_W+1)'(DATA_BYTES - 1);
        oob       = (last_addr >= (ADDR_W+1)'(DEPTH));
    end
`else
    always_comb begin
        oob = 1'b0;
    end
`endif

    // Per-lane addressing; the same index serves the write and the read port.
    always_comb begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_idx[i]   = IDX_W'(byte_index(32'(req_addr), i, DEPTH));
            lane_wdata[i] = req_wdata[8*i +: 8];
            bank_we[i]    = accept && req_we && req_mask[i] && !oob;
            rd_word[8*i +: 8] = lane_rdata[i];
        end
    end

    mem_byte_bank #(
        .DEPTH      (DEPTH),
        .DATA_BYTES (DATA_BYTES),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk     (clk),
        .wr_en   (bank_we),
        .wr_idx  (lane_idx),
        .wr_data (lane_wdata),
        .rd_idx  (lane_idx),
        .rd_data (lane_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Read data is captured now, so later writes cannot
                    // disturb a pending response.
                    rdata_d = (req_we || oob) ? '0 : rd_word;
                    err_d   = oob;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                cnt_d        = '0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_pipelined_memory.sv
// -----------------------------------------------------------------------------
// tb_pipelined_memory
// Three instances of pipelined_memory (LATENCY 1, 3 and 4) driven one at a
// time against a byte-array reference model. Honors MEM_BOUNDS_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_pipelined_memory;

    localparam int ADDR_W = 16;
    localparam int NB     = 8;
    localparam int DEPTH  = 65536;
    localparam int NDUT   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_we     [NDUT];
    logic [7:0]  req_mask   [NDUT];
    logic [15:0] req_addr   [NDUT];
    logic [63:0] req_wdata  [NDUT];
    logic        resp_valid [NDUT];
    logic        resp_ready [NDUT];
    logic [63:0] resp_rdata [NDUT];
    logic        resp_err   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipelined_memory #(
            .ADDR_W     (ADDR_W),
            .DATA_BYTES (NB),
            .DEPTH      (DEPTH),
            .LATENCY    (g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_mask   (req_mask[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    logic [7:0] ref_mem [NDUT][DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_oob(input logic [15:0] addr);
`ifdef MEM_BOUNDS_CHECK_EN
        return (int'(addr) + NB - 1) >= DEPTH;
`else
        return (addr == 16'h0) && 1'b0;
`endif
    endfunction

    // Reference behaviour of one accepted access.
    task automatic model_access(input int d, input bit we, input logic [7:0] mask,
                                input logic [15:0] addr, input logic [63:0] wdata,
                                output logic [63:0] exp_rd, output logic exp_err);
        bit o;
        o       = model_oob(addr);
        exp_err = o;
        exp_rd  = '0;
        for (int i = 0; i < NB; i++) begin
            int idx;
            idx = (int'(addr) + i) % DEPTH;
            if (!o) begin
                if (we) begin
                    if (mask[i]) ref_mem[d][idx] = wdata[8*i +: 8];
                end else begin
                    exp_rd[8*i +: 8] = ref_mem[d][idx];
                end
            end
        end
    endtask

    // One complete transaction: request, latency check, optional hold of the
    // response with resp_ready low, then consumption. With junk set, a bogus
    // write to 0x0100 is kept on the request port until after consumption.
    task automatic xact(input int d, input bit we, input logic [7:0] mask,
                        input logic [15:0] addr, input logic [63:0] wdata,
                        input int hold, input bit junk, input string tag,
                        output logic [63:0] rd, output logic er);
        logic [63:0] exp_rd;
        logic [63:0] held;
        logic        exp_err;
        int          lat;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_mask[d]   = mask;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = 1'b0;
        check({tag, ".ready"}, 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        model_access(d, we, mask, addr, wdata, exp_rd, exp_err);
        @(negedge clk);
        if (junk) begin
            req_we[d]    = 1'b1;
            req_mask[d]  = 8'hFF;
            req_addr[d]  = 16'h0100;
            req_wdata[d] = 64'hDEAD_BEEF_0BAD_F00D;
        end else begin
            req_valid[d] = 1'b0;
        end
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(lat_of(d)));
        held = resp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            check({tag, ".hold_ready"}, 64'(req_ready[d]), 64'd0);
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(resp_valid[d]), 64'd1);
            check({tag, ".hold_rdata"}, resp_rdata[d], held);
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        check({tag, ".rdata"}, resp_rdata[d], exp_rd);
        check({tag, ".err"}, 64'(resp_err[d]), 64'(exp_err));
        resp_ready[d] = 1'b1;
        @(negedge clk);
        check({tag, ".to_idle"}, {62'd0, resp_valid[d], req_ready[d]}, 64'd1);
        resp_ready[d] = 1'b0;
        req_valid[d]  = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_mask[d]   = '0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset.valid", 64'(resp_valid[d]), 64'd0);
            check("reset.rdata", resp_rdata[d], 64'd0);
            check("reset.err",   64'(resp_err[d]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset.ready", 64'(req_ready[d]), 64'd1);
        end

        // Put every byte the bench will read into a known state.
        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 16'h0200; a += 8) begin
                xact(d, 1'b1, 8'hFF, 16'(a), {$urandom, $urandom}, 0, 1'b0, "fill", rd, er);
            end
            xact(d, 1'b1, 8'hFF, 16'hFFF0, {$urandom, $urandom}, 0, 1'b0, "fill", rd, er);
            xact(d, 1'b1, 8'hFF, 16'hFFF8, {$urandom, $urandom}, 0, 1'b0, "fill", rd, er);
        end

        // Full write then read back, latency 1.
        xact(0, 1'b1, 8'hFF, 16'h0100, 64'h1122334455667788, 0, 1'b0, "wr_full", rd, er);
        check("wr_full.zero_rdata", rd, 64'd0);
        xact(0, 1'b0, 8'h00, 16'h0100, 64'd0, 0, 1'b0, "rd_full", rd, er);
        check("rd_full.const", rd, 64'h1122334455667788);

        // Unaligned reads over that data.
        xact(0, 1'b0, 8'h5A, 16'h0103, 64'd0, 0, 1'b0, "rd_0103", rd, er);
        check("rd_0103.low", {32'd0, rd[31:0]}, 64'h22334455);
        xact(0, 1'b0, 8'h00, 16'h0104, 64'd0, 0, 1'b0, "rd_0104", rd, er);
        check("rd_0104.low", {32'd0, rd[31:0]}, 64'h11223344);

        // Sparse mask.
        xact(0, 1'b1, 8'h0A, 16'h0100, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, "wr_mask", rd, er);
        xact(0, 1'b0, 8'h00, 16'h0100, 64'd0, 0, 1'b0, "rd_mask", rd, er);
        check("rd_mask.const", rd, 64'h11223344FF66FF88);

        // Zero mask changes nothing.
        xact(0, 1'b1, 8'h00, 16'h0100, 64'h0, 0, 1'b0, "wr_nomask", rd, er);
        xact(0, 1'b0, 8'h00, 16'h0100, 64'd0, 0, 1'b0, "rd_nomask", rd, er);
        check("rd_nomask.const", rd, 64'h11223344FF66FF88);

        // Access straddling the top of memory.
        xact(0, 1'b1, 8'hFF, 16'hFFFC, 64'hA1A2A3A4A5A6A7A8, 0, 1'b0, "wr_top", rd, er);
`ifdef MEM_BOUNDS_CHECK_EN
        check("wr_top.err_const", 64'(er), 64'd1);
`else
        check("wr_top.err_const", 64'(er), 64'd0);
`endif
        xact(0, 1'b0, 8'h00, 16'hFFF8, 64'd0, 0, 1'b0, "rd_fff8", rd, er);
        xact(0, 1'b0, 8'h00, 16'h0000, 64'd0, 0, 1'b0, "rd_0000", rd, er);
`ifndef MEM_BOUNDS_CHECK_EN
        check("rd_0000.wrap_low", {32'd0, rd[31:0]}, 64'hA1A2A3A4);
`endif
        xact(0, 1'b0, 8'h00, 16'hFFFC, 64'd0, 0, 1'b0, "rd_fffc", rd, er);
`ifndef MEM_BOUNDS_CHECK_EN
        check("rd_fffc.wrap_const", rd, 64'hA1A2A3A4A5A6A7A8);
`endif

        // Latency 4: response held for 3 cycles while a bogus request waits.
        xact(2, 1'b1, 8'hFF, 16'h0100, 64'h1122334455667788, 0, 1'b0, "l4_wr", rd, er);
        xact(2, 1'b0, 8'h00, 16'h0100, 64'd0, 3, 1'b1, "l4_hold", rd, er);
        check("l4_hold.const", rd, 64'h1122334455667788);
        xact(2, 1'b0, 8'h00, 16'h0100, 64'd0, 0, 1'b0, "l4_after", rd, er);
        check("l4_after.const", rd, 64'h1122334455667788);

        // Latency 3: reset during WAIT of a write keeps the committed data.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_mask[1] = 8'hFF;
        req_addr[1] = 16'h0040; req_wdata[1] = 64'h0123456789ABCDEF;
        @(posedge clk);
        model_access(1, 1'b1, 8'hFF, 16'h0040, 64'h0123456789ABCDEF, rd, er);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xact(1, 1'b0, 8'h00, 16'h0040, 64'd0, 0, 1'b0, "l3_rst_wr", rd, er);
        check("l3_rst_wr.const", rd, 64'h0123456789ABCDEF);

        // Latency 3: reset the cycle after a read is accepted.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_mask[1] = 8'h00;
        req_addr[1] = 16'h0100; resp_ready[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("l3_rst_rd.ready", 64'(req_ready[1]), 64'd1);
        for (int c = 0; c < 6; c++) begin
            check("l3_rst_rd.no_valid", 64'(resp_valid[1]), 64'd0);
            @(negedge clk);
        end

        // Randomized traffic on every instance.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 40; n++) begin
                logic [15:0] a;
                if ($urandom_range(0, 3) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
                else                           a = 16'h0080 + 16'($urandom_range(0, 16'h0100));
                xact(d, 1'($urandom_range(0, 1)), 8'($urandom), a, {$urandom, $urandom},
                     $urandom_range(0, 2), 1'b0, "rand", rd, er);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
